// File: rtl/frame_normalize_if.sv
// Sample-stream bus of the block-floating-point normalizer: input handshake plus
// normalized output stream with its frame exponent and frame markers.
interface frame_normalize_if;
   logic [15:0] x;
   logic        v;
   logic        ready;
   logic [15:0] y;
   logic        vout;
   logic [3:0]  shift;
   logic        frame_start;
   logic        frame_end;

   modport master (
      output x, v,
      input  ready, y, vout, shift, frame_start, frame_end
   );

   modport slave (
      input  x, v,
      output ready, y, vout, shift, frame_start, frame_end
   );
endinterface

// File: rtl/frame_normalize.sv
// Block-floating-point normalizer: buffers one frame, finds the largest common
// left shift that cannot overflow, then replays the frame shifted with its exponent.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   FILL  | ready=1, write accepted samples, accumulate sign-redundancy mask
//   CALC  | one cycle: shift = leading zeros of mask (cap 15), clear wr/mask
//   DRAIN | read buffer once per cycle, emit FRAME_LEN shifted samples
module frame_normalize #(
   parameter int FRAME_LEN = 256,
   parameter int ADDR_W    = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   frame_normalize_if.slave bus
);

   typedef enum logic [1:0] {FILL, CALC, DRAIN} state_t;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_LEN - 1);

   state_t            st_q;
   logic [ADDR_W-1:0] wr_q;
   logic [ADDR_W-1:0] rd_q;
   logic [14:0]       mask_q;
   logic [14:0]       mask_d;
   logic [3:0]        shift_q;
   logic [3:0]        shift_d;
   logic              ready_q;
   logic              issuing_q;
   logic              p_vld_q;
   logic              p_first_q;
   logic              p_last_q;
   logic [15:0]       rdat_q;
   logic [15:0]       y_q;
   logic              vout_q;
   logic              fs_q;
   logic              fe_q;

   logic [15:0]       buf_q [FRAME_LEN];

   logic              accept;
   logic              rd_en;

   function automatic logic [3:0] lzc15(input logic [14:0] m);
      logic [3:0] n;
      logic       found;
      n     = 4'd15;
      found = 1'b0;
      for (int i = 14; i >= 0; i--) begin
         if (!found && m[i]) begin
            n     = 4'(14 - i);
            found = 1'b1;
         end
      end
      return n;
   endfunction

   assign accept = bus.v && ready_q && (st_q == FILL);
   assign rd_en  = (st_q == DRAIN) && issuing_q;

   // Bits that differ from the sign bit mark magnitude the shift must preserve.
   always_comb begin
      mask_d  = mask_q | (bus.x[14:0] ^ {15{bus.x[15]}});
      shift_d = lzc15(mask_q);
   end

   always_ff @(posedge clk) begin
      if (accept) buf_q[wr_q] <= bus.x;
   end

   always_ff @(posedge clk) begin
      if (rd_en) rdat_q <= buf_q[rd_q];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q      <= FILL;
         wr_q      <= '0;
         rd_q      <= '0;
         mask_q    <= '0;
         shift_q   <= '0;
         ready_q   <= 1'b1;
         issuing_q <= 1'b0;
         p_vld_q   <= 1'b0;
         p_first_q <= 1'b0;
         p_last_q  <= 1'b0;
         y_q       <= '0;
         vout_q    <= 1'b0;
         fs_q      <= 1'b0;
         fe_q      <= 1'b0;
      end else begin
         // Read pipeline: issue -> read data -> shifted output register.
         p_vld_q   <= rd_en;
         p_first_q <= rd_en && (rd_q == '0);
         p_last_q  <= rd_en && (rd_q == LAST);
         vout_q    <= p_vld_q;
         fs_q      <= p_first_q;
         fe_q      <= p_last_q;
         if (p_vld_q) y_q <= rdat_q << shift_q;

         case (st_q)
            FILL: begin
               if (accept) begin
                  wr_q   <= wr_q + 1'b1;
                  mask_q <= mask_d;
                  if (wr_q == LAST) begin
                     st_q    <= CALC;
                     ready_q <= 1'b0;
                  end
               end
            end
            CALC: begin
               shift_q   <= shift_d;
               wr_q      <= '0;
               mask_q    <= '0;
               rd_q      <= '0;
               issuing_q <= 1'b1;
               st_q      <= DRAIN;
            end
            DRAIN: begin
               if (rd_en) begin
                  rd_q <= rd_q + 1'b1;
                  if (rd_q == LAST) issuing_q <= 1'b0;
               end
               if (fe_q) begin
                  st_q    <= FILL;
                  ready_q <= 1'b1;
               end
            end
            default: begin
               st_q    <= FILL;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.ready       = ready_q;
   assign bus.y           = y_q;
   assign bus.vout        = vout_q;
   assign bus.shift       = shift_q;
   assign bus.frame_start = fs_q;
   assign bus.frame_end   = fe_q;

endmodule
